// File: rtl/fp32_pkg.sv
// Shared binary32 constants, field layout and classification helpers for the FP adder.
package fp32_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == '1) && (x.frac != '0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == '1) && (x.frac == '0);
    endfunction

endpackage

// File: rtl/fp32_adder_lzc.sv
// 27-bit leading-zero counter used to renormalise the adder result after cancellation.
// An all-zero input reports 27.
module fp_lzc (
    input  logic [26:0] din,
    output logic [4:0]  cnt
);

    // Later iterations overwrite earlier ones, so the highest set bit decides the count.
    always_comb begin
        cnt = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (din[i]) cnt = 5'(26 - i);
        end
    end

endmodule

// File: rtl/fp32_adder.sv
// Registered IEEE-754 binary32 adder (round-to-nearest-even), one result per clock.
// Define FP_ADD_DENORM_EN for gradual underflow; otherwise subnormals are flushed to zero.
module fp32_adder #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EXP_W+FRAC_W:0] in1,
    input  logic [EXP_W+FRAC_W:0] in2,
    output logic [EXP_W+FRAC_W:0] out1
);
    import fp32_pkg::*;

    function automatic logic [26:0] align_shift(input logic [26:0] m, input logic [7:0] d);
        logic [26:0] shifted;
        logic [26:0] lost;
        if (d >= 8'd26) return {26'd0, |m};
        shifted = m >> d;
        lost    = m & ~({27{1'b1}} << d);
        return shifted | {26'd0, |lost};
    endfunction

    // Input layout {mant[23:0], g, r, s}; bit 24 of the result is the rounding carry.
    function automatic logic [24:0] round_rne(input logic [26:0] m);
        logic up;
        up = m[2] & (m[1] | m[0] | m[3]);
        return {1'b0, m[26:3]} + {24'd0, up};
    endfunction

    function automatic fp32_t pack_sat(input logic s, input logic signed [9:0] e,
                                       input logic [23:0] m);
        if (e >= 10'(EXP_MAX)) return {s, 8'hFF, 23'd0};
`ifdef FP_ADD_DENORM_EN
        return {s, (m[23] ? e[7:0] : 8'd0), m[22:0]};
`else
        if ((e <= 10'sd0) || !m[23]) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
`endif
    endfunction

    fp32_t       a, b;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;

    assign a = in1;
    assign b = in2;

    always_comb begin
`ifdef FP_ADD_DENORM_EN
        ea = (a.exp == 8'd0) ? 8'd1 : a.exp;
        eb = (b.exp == 8'd0) ? 8'd1 : b.exp;
        ma = {a.exp != 8'd0, a.frac};
        mb = {b.exp != 8'd0, b.frac};
`else
        ea = a.exp;
        eb = b.exp;
        ma = (a.exp == 8'd0) ? 24'd0 : {1'b1, a.frac};
        mb = (b.exp == 8'd0) ? 24'd0 : {1'b1, b.frac};
`endif
    end

    logic        a_big, sbig, eff_sub;
    logic [7:0]  ebig, esmall, ediff;
    logic [23:0] mbig, msmall;
    logic [26:0] small_x;
    logic [27:0] sum;

    always_comb begin
        a_big   = ({ea, ma} >= {eb, mb});
        sbig    = a_big ? a.sign : b.sign;
        ebig    = a_big ? ea : eb;
        esmall  = a_big ? eb : ea;
        mbig    = a_big ? ma : mb;
        msmall  = a_big ? mb : ma;
        ediff   = ebig - esmall;
        eff_sub = a.sign ^ b.sign;
        small_x = align_shift({msmall, 3'b000}, ediff);
        sum     = eff_sub ? ({1'b0, mbig, 3'b000} - {1'b0, small_x})
                          : ({1'b0, mbig, 3'b000} + {1'b0, small_x});
    end

    logic [4:0]        lzc, shamt;
    logic [26:0]       norm;
    logic signed [9:0] e_norm;
    logic              zero_sum;

    fp_lzc u_lzc (
        .din (sum[26:0]),
        .cnt (lzc)
    );

    always_comb begin
        zero_sum = (sum == 28'd0);
        shamt    = lzc;
        norm     = sum[26:0];
        e_norm   = $signed({2'b00, ebig});
        if (sum[27]) begin
            norm   = {sum[27:2], sum[1] | sum[0]};
            e_norm = $signed({2'b00, ebig}) + 10'sd1;
        end else begin
`ifdef FP_ADD_DENORM_EN
            // Stop the left shift at exponent 1 so tiny results land in the subnormal encoding.
            if ({3'd0, lzc} > (ebig - 8'd1)) shamt = 5'(ebig - 8'd1);
`endif
            norm   = sum[26:0] << shamt;
            e_norm = $signed({2'b00, ebig}) - $signed({5'd0, shamt});
        end
    end

    logic [24:0]       rnd;
    logic [23:0]       mant_f;
    logic signed [9:0] e_fin;
    logic              rsign;
    fp32_t             res_p0;

    always_comb begin
        rnd    = round_rne(norm);
        mant_f = rnd[24] ? rnd[24:1] : rnd[23:0];
        e_fin  = rnd[24] ? (e_norm + 10'sd1) : e_norm;
        rsign  = zero_sum ? (a.sign & b.sign) : sbig;
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a.sign != b.sign)))
            res_p0 = QNAN;
        else if (is_inf(a))
            res_p0 = a;
        else if (is_inf(b))
            res_p0 = b;
        else
            res_p0 = pack_sat(rsign, e_fin, mant_f);
    end

    // Stage boundary: combinational sum into the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out1 <= '0;
        else     out1 <= res_p0;
    end

endmodule

// File: tb/tb_fp32_adder.sv
// Bench for fp32_adder: exact-integer reference model, directed vectors and random back-to-back traffic.
module tb_fp32_adder;
    import fp32_pkg::*;

`ifdef FP_ADD_DENORM_EN
    localparam bit DENORM = 1'b1;
`else
    localparam bit DENORM = 1'b0;
`endif
    // Reference values are integers in units of the smallest subnormal, 2^-149.
    localparam int UNIT_EXP = BIAS + FRAC_W - 1;
    localparam int NV = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in1, in2, out1;

    int errors = 0;
    int checks = 0;

    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] vr [NV];

    logic [31:0] cur_lit, exp_model, exp_lit, ra, rb;
    logic        cur_lit_en, exp_vld, lit_vld;
    int          cur_idx, exp_idx;

    fp32_adder dut (
        .clk  (clk),
        .rst  (rst),
        .in1  (in1),
        .in2  (in2),
        .out1 (out1)
    );

    always #5 clk = ~clk;

    function automatic logic signed [299:0] value(input logic [31:0] x);
        logic [299:0] mag;
        if (x[30:23] == 8'd0)
            mag = DENORM ? 300'(x[22:0]) : '0;
        else
            mag = 300'({1'b1, x[22:0]}) << (int'(x[30:23]) - BIAS - FRAC_W + UNIT_EXP);
        return x[31] ? -$signed(mag) : $signed(mag);
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] x, input logic [31:0] y);
        logic signed [299:0] s;
        logic [299:0]        m, q, rem, half;
        logic                sg, xn, yn, xi, yi;
        int                  p, sh, e;
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        if (xn || yn) return QNAN;
        if (xi && yi && (x[31] != y[31])) return QNAN;
        if (xi) return x;
        if (yi) return y;
        s = value(x) + value(y);
        if (s == 0) return (x[31] & y[31]) ? 32'h8000_0000 : 32'h0000_0000;
        sg = (s < 0);
        m  = 300'(sg ? -s : s);
        p  = 0;
        for (int i = 0; i < 300; i++) if (m[i]) p = i;
        if (p < FRAC_W) return DENORM ? {sg, 8'd0, m[22:0]} : {sg, 31'd0};
        sh   = p - FRAC_W;
        e    = sh + 1;
        q    = m >> sh;
        rem  = m - (q << sh);
        half = (sh == 0) ? '0 : (300'd1 << (sh - 1));
        if ((sh > 0) && ((rem > half) || ((rem == half) && q[0]))) q = q + 1;
        if (q[24]) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= EXP_MAX) return sg ? NEG_INF : POS_INF;
        return {sg, e[7:0], q[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Expectations travel one clock behind the inputs, like the DUT result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_vld <= 1'b0;
            lit_vld <= 1'b0;
        end else begin
            exp_vld   <= 1'b1;
            exp_model <= model_add(in1, in2);
            exp_lit   <= cur_lit;
            lit_vld   <= cur_lit_en;
            exp_idx   <= cur_idx;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("reset_hold", out1, 32'h0000_0000);
        end else if (exp_vld) begin
            check($sformatf("model v%0d a=%08h b=%08h", exp_idx, ra, rb), out1, exp_model);
            if (lit_vld) check($sformatf("directed v%0d", exp_idx), out1, exp_lit);
        end
    end

    initial begin
        va = '{32'h3F80_0000, 32'h80F0_0000, 32'h3FC0_0000, 32'h8000_0000, 32'h3F80_0001,
               32'h3F80_0000, 32'h3F80_0001, 32'h7F7F_FFFF, 32'h7F80_0000, 32'h7FA0_0000,
               32'hFF80_0000, 32'h0000_0001, 32'h0000_0000, 32'h4040_0000};
        vb = '{32'h3F80_0000, 32'h3F80_0000, 32'hBFC0_0000, 32'h8000_0000, 32'hBF80_0000,
               32'h3380_0000, 32'h3380_0000, 32'h7F7F_FFFF, 32'hFF80_0000, 32'h3F80_0000,
               32'h4200_0000, 32'h0000_0001, 32'h8000_0000, 32'hC000_0000};
        vr = '{32'h4000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h8000_0000, 32'h3400_0000,
               32'h3F80_0000, 32'h3F80_0002, 32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000,
               32'hFF80_0000, (DENORM ? 32'h0000_0002 : 32'h0000_0000), 32'h0000_0000,
               32'h3F80_0000};

        rst        = 1'b1;
        in1        = 32'h3F80_0000;
        in2        = 32'h3F80_0000;
        ra         = in1;
        rb         = in2;
        cur_lit    = '0;
        cur_lit_en = 1'b0;
        cur_idx    = 0;

        for (int i = 0; i < NV; i++)
            check($sformatf("model_pin v%0d", i), model_add(va[i], vb[i]), vr[i]);

        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in1 = va[i]; in2 = vb[i]; ra = va[i]; rb = vb[i];
            cur_lit = vr[i]; cur_lit_en = 1'b1; cur_idx = i;
        end
        @(negedge clk);
        cur_lit_en = 1'b0;

        // Asynchronous reset between edges must clear the output at once.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", out1, 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            if (k % 4 == 1)
                rb = {~ra[31], ra[30:0]} ^ 32'($urandom_range(0, 7));
            else if (k % 2 == 0)
                rb[30:23] = ra[30:23] ^ 8'($urandom_range(0, 3));
            in1 = ra; in2 = rb; cur_idx = 100 + k;
        end
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
